// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle controller.
//   state_e    - controller FSM state encoding
//   OP_*       - low-nibble opcode map
//   ALU_ADD    - ALU function used for address/immediate arithmetic
//   ctrl_out_t - bundle of datapath strobes and status flags
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_e;

  localparam logic [3:0] OP_ADDI    = 4'h8;
  localparam logic [3:0] OP_LOAD    = 4'h9;
  localparam logic [3:0] OP_STORE   = 4'hA;
  localparam logic [3:0] OP_JMP     = 4'hB;
  localparam logic [3:0] OP_BEQ     = 4'hC;
  localparam logic [3:0] OP_NOP     = 4'hD;
  localparam logic [3:0] OP_HALT    = 4'hE;
  localparam logic [3:0] OP_ILLEGAL = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;

  typedef struct packed {
    logic       ir_load;
    logic       pc_inc;
    logic       pc_sel;
    logic       mar_sel;
    logic       mem_en;
    logic       mem_sel;
    logic       w_en;
    logic       immed_sel;
    logic       flag_en;
    logic [3:0] alu_func;
    logic       busy;
    logic       halted;
    logic       fault;
  } ctrl_out_t;

  // Opcodes 0x0-0x7 are register-register ALU operations.
  function automatic logic is_alu_reg(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational strobe decoder for multicycle_ctrl.
//   state_i     - current controller state
//   op_q_i      - latched opcode (low nibble)
//   zero_flag_i - ALU zero flag, selects the BEQ branch
//   out_o       - datapath strobes and status flags
// ir_load/pc_inc are raised for the whole FETCH state; the top qualifies
// them with mem_ready.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_q_i,
  input  logic       zero_flag_i,
  output ctrl_out_t  out_o
);

  always_comb begin
    out_o = '0;
    case (state_i)
      ST_FETCH: begin
        out_o.busy    = 1'b1;
        out_o.mem_en  = 1'b1;
        out_o.ir_load = 1'b1;
        out_o.pc_inc  = 1'b1;
      end
      ST_DECODE: out_o.busy = 1'b1;
      ST_EXEC: begin
        out_o.busy = 1'b1;
        if (is_alu_reg(op_q_i)) begin
          out_o.alu_func = op_q_i;
          out_o.flag_en  = 1'b1;
        end else begin
          case (op_q_i)
            OP_ADDI: begin
              out_o.immed_sel = 1'b1;
              out_o.alu_func  = ALU_ADD;
              out_o.flag_en   = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              out_o.immed_sel = 1'b1;
              out_o.alu_func  = ALU_ADD;
            end
            OP_JMP:  out_o.pc_sel = 1'b1;
            OP_BEQ:  out_o.pc_sel = zero_flag_i;
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        out_o.busy    = 1'b1;
        out_o.mem_en  = 1'b1;
        out_o.mar_sel = 1'b1;
        out_o.mem_sel = (op_q_i == OP_STORE);
      end
      ST_WB: begin
        out_o.busy = 1'b1;
        out_o.w_en = 1'b1;
      end
      ST_HALT: out_o.halted = 1'b1;
      ST_ERR:  out_o.fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM.
//   clk, rst_n            - clock, async active-low reset
//   en                    - run enable, sampled in IDLE and at boundaries
//   op                    - opcode from IR, valid in DECODE
//   zero_flag, mem_ready  - datapath status inputs
//   ir_load..flag_en      - datapath strobes; alu_func - ALU operation
//   busy, halted, fault   - status; instr_cnt - retired instructions
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_sel,
  output logic             mar_sel,
  output logic             mem_en,
  output logic             mem_sel,
  output logic             w_en,
  output logic             immed_sel,
  output logic             flag_en,
  output logic [3:0]       alu_func,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;
  logic             op_hi_nz;
  logic             op_illegal;
  logic             wait_last;
  ctrl_out_t        dec;

  // Upper opcode bits only matter for legality, so only the low nibble is
  // kept in op_q; illegal opcodes never reach a state that reads op_q.
  if (OP_W > 4) begin : g_op_hi
    assign op_hi_nz = |op[OP_W-1:4];
  end else begin : g_op_nohi
    assign op_hi_nz = 1'b0;
  end

  assign op_illegal = op_hi_nz || (op[3:0] == OP_ILLEGAL);
  assign wait_last  = (wait_q == WT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready)      state_d = ST_DECODE;
        else if (wait_last) state_d = ST_ERR;
        else                wait_d  = wait_q + WT_W'(1);
      end
      ST_DECODE: begin
        if (op_illegal) begin
          state_d = ST_ERR;
        end else if (op[3:0] == OP_HALT) begin
          state_d = ST_HALT;
          cnt_inc = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_alu_reg(op_q) || op_q == OP_ADDI) begin
          state_d = ST_WB;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          cnt_inc = 1'b1;
          wait_d  = '0;
          state_d = en ? ST_FETCH : ST_IDLE;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            cnt_inc = 1'b1;
            wait_d  = '0;
            state_d = en ? ST_FETCH : ST_IDLE;
          end
        end else if (wait_last) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + WT_W'(1);
        end
      end
      ST_WB: begin
        cnt_inc = 1'b1;
        wait_d  = '0;
        state_d = en ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: if (!en) state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == ST_DECODE) op_q <= op[3:0];
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  ctrl_decode u_decode (
    .state_i     (state_q),
    .op_q_i      (op_q),
    .zero_flag_i (zero_flag),
    .out_o       (dec)
  );

  assign ir_load   = dec.ir_load & mem_ready;
  assign pc_inc    = dec.pc_inc & mem_ready;
  assign pc_sel    = dec.pc_sel;
  assign mar_sel   = dec.mar_sel;
  assign mem_en    = dec.mem_en;
  assign mem_sel   = dec.mem_sel;
  assign w_en      = dec.w_en;
  assign immed_sel = dec.immed_sel;
  assign flag_en   = dec.flag_en;
  assign alu_func  = dec.alu_func;
  assign busy      = dec.busy;
  assign halted    = dec.halted;
  assign fault     = dec.fault;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// Output vector layout: {ir_load,pc_inc,pc_sel,mar_sel,mem_en,mem_sel,w_en,
// immed_sel,flag_en} (9) , alu_func (4), {busy,halted,fault} (3), instr_cnt (16).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  op = '0;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_inc, pc_sel, mar_sel, mem_en, mem_sel, w_en;
  logic        immed_sel, flag_en, busy, halted, fault;
  logic [3:0]  alu_func;
  logic [15:0] instr_cnt;

  // Hand-coded strobe patterns (bit 8 = ir_load ... bit 0 = flag_en).
  localparam logic [8:0] S_NONE = 9'h000;
  localparam logic [8:0] S_FW   = 9'h010; // fetch, waiting
  localparam logic [8:0] S_FR   = 9'h190; // fetch, ready: ir_load+pc_inc+mem_en
  localparam logic [8:0] S_ADDI = 9'h003; // immed_sel+flag_en
  localparam logic [8:0] S_LS   = 9'h002; // immed_sel
  localparam logic [8:0] S_ALU  = 9'h001; // flag_en
  localparam logic [8:0] S_ML   = 9'h030; // mar_sel+mem_en
  localparam logic [8:0] S_MS   = 9'h038; // mar_sel+mem_en+mem_sel
  localparam logic [8:0] S_WB   = 9'h004; // w_en
  localparam logic [8:0] S_PC   = 9'h040; // pc_sel
  localparam logic [2:0] T_Z = 3'b000, T_B = 3'b100, T_H = 3'b010, T_F = 3'b001;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(6), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .op        (op),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_sel    (pc_sel),
    .mar_sel   (mar_sel),
    .mem_en    (mem_en),
    .mem_sel   (mem_sel),
    .w_en      (w_en),
    .immed_sel (immed_sel),
    .flag_en   (flag_en),
    .alu_func  (alu_func),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .instr_cnt (instr_cnt)
  );

  // Monitor: compares on the falling edge whenever an expectation is pending.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {ir_load, pc_inc, pc_sel, mar_sel, mem_en, mem_sel, w_en,
               immed_sel, flag_en, alu_func, busy, halted, fault, instr_cnt};
        n_total++;
        if (act !== e.v) begin
          n_bad++;
          $display("FAIL %s: got=%h want=%h", e.tag, act, e.v);
        end
      end
    end
  end

  task automatic push(input string tag, input logic [8:0] s, input logic [3:0] a,
                      input logic [2:0] st, input logic [15:0] c);
    exp_t e;
    e.tag = tag;
    e.v   = {s, a, st, c};
    exp_q.push_back(e);
  endtask

  // Drive inputs for the cycle after the next rising edge and record the
  // outputs expected in that same cycle.
  task automatic step(input string tag, input logic e_i, input logic rdy, input logic zf,
                      input logic [5:0] o, input logic [8:0] s, input logic [3:0] a,
                      input logic [2:0] st, input logic [15:0] c);
    @(posedge clk);
    #1;
    en = e_i; mem_ready = rdy; zero_flag = zf; op = o;
    push(tag, s, a, st, c);
  endtask

  // Asserts reset mid-cycle (no clock edge before the check), then releases.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0; en = 1'b0; mem_ready = 1'b0;
    push(tag, S_NONE, 4'h0, T_Z, 16'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 push("reset", S_NONE, 4'h0, T_Z, 16'd0);
    #11 rst_n = 1'b1;
    step("idle0",      0, 0, 0, 6'h08, S_NONE, 4'h0, T_Z, 16'd0);
    // ADDI, memory ready immediately, stop afterwards
    step("addi_idle",  1, 1, 0, 6'h08, S_NONE, 4'h0, T_Z, 16'd0);
    step("addi_fetch", 1, 1, 0, 6'h08, S_FR,   4'h0, T_B, 16'd0);
    step("addi_dec",   1, 1, 0, 6'h08, S_NONE, 4'h0, T_B, 16'd0);
    step("addi_exec",  1, 1, 0, 6'h08, S_ADDI, 4'h0, T_B, 16'd0);
    step("addi_wb",    0, 1, 0, 6'h08, S_WB,   4'h0, T_B, 16'd0);
    step("addi_done",  0, 0, 0, 6'h08, S_NONE, 4'h0, T_Z, 16'd1);
    // LOAD with three wait cycles in MEM, chained into BEQ
    step("ld_idle",    1, 1, 0, 6'h09, S_NONE, 4'h0, T_Z, 16'd1);
    step("ld_fetch",   1, 1, 0, 6'h09, S_FR,   4'h0, T_B, 16'd1);
    step("ld_dec",     1, 1, 0, 6'h09, S_NONE, 4'h0, T_B, 16'd1);
    step("ld_exec",    1, 0, 0, 6'h09, S_LS,   4'h0, T_B, 16'd1);
    step("ld_mem0",    1, 0, 0, 6'h09, S_ML,   4'h0, T_B, 16'd1);
    step("ld_mem1",    1, 0, 0, 6'h09, S_ML,   4'h0, T_B, 16'd1);
    step("ld_mem2",    1, 0, 0, 6'h09, S_ML,   4'h0, T_B, 16'd1);
    step("ld_mem3",    1, 1, 0, 6'h09, S_ML,   4'h0, T_B, 16'd1);
    step("ld_wb",      1, 1, 0, 6'h0C, S_WB,   4'h0, T_B, 16'd1);
    // BEQ taken then not taken
    step("beq1_fetch", 1, 1, 0, 6'h0C, S_FR,   4'h0, T_B, 16'd2);
    step("beq1_dec",   1, 1, 0, 6'h0C, S_NONE, 4'h0, T_B, 16'd2);
    step("beq1_exec",  1, 1, 1, 6'h0C, S_PC,   4'h0, T_B, 16'd2);
    step("beq0_fetch", 1, 1, 0, 6'h0C, S_FR,   4'h0, T_B, 16'd3);
    step("beq0_dec",   1, 1, 0, 6'h0C, S_NONE, 4'h0, T_B, 16'd3);
    step("beq0_exec",  1, 1, 0, 6'h05, S_NONE, 4'h0, T_B, 16'd3);
    // ALU register op 0x5
    step("alu_fetch",  1, 1, 0, 6'h05, S_FR,   4'h0, T_B, 16'd4);
    step("alu_dec",    1, 1, 0, 6'h05, S_NONE, 4'h0, T_B, 16'd4);
    step("alu_exec",   1, 1, 0, 6'h05, S_ALU,  4'h5, T_B, 16'd4);
    step("alu_wb",     1, 1, 0, 6'h0A, S_WB,   4'h0, T_B, 16'd4);
    // STORE with en dropped mid-instruction: completes, then IDLE
    step("st_fetch",   1, 1, 0, 6'h0A, S_FR,   4'h0, T_B, 16'd5);
    step("st_dec",     0, 1, 0, 6'h0A, S_NONE, 4'h0, T_B, 16'd5);
    step("st_exec",    0, 1, 0, 6'h0A, S_LS,   4'h0, T_B, 16'd5);
    step("st_mem",     0, 1, 0, 6'h0A, S_MS,   4'h0, T_B, 16'd5);
    step("st_done",    0, 0, 0, 6'h0B, S_NONE, 4'h0, T_Z, 16'd6);
    // JMP with one fetch wait, then NOP
    step("jmp_idle",   1, 0, 0, 6'h0B, S_NONE, 4'h0, T_Z, 16'd6);
    step("jmp_fwait",  1, 0, 0, 6'h0B, S_FW,   4'h0, T_B, 16'd6);
    step("jmp_fetch",  1, 1, 0, 6'h0B, S_FR,   4'h0, T_B, 16'd6);
    step("jmp_dec",    1, 1, 0, 6'h0B, S_NONE, 4'h0, T_B, 16'd6);
    step("jmp_exec",   1, 1, 0, 6'h0D, S_PC,   4'h0, T_B, 16'd6);
    step("nop_fetch",  1, 1, 0, 6'h0D, S_FR,   4'h0, T_B, 16'd7);
    step("nop_dec",    1, 1, 0, 6'h0D, S_NONE, 4'h0, T_B, 16'd7);
    step("nop_exec",   0, 1, 0, 6'h0E, S_NONE, 4'h0, T_B, 16'd7);
    step("nop_done",   0, 0, 0, 6'h0E, S_NONE, 4'h0, T_Z, 16'd8);
    // HALT: counted on entry, leaves only when en drops
    step("hlt_idle",   1, 1, 0, 6'h0E, S_NONE, 4'h0, T_Z, 16'd8);
    step("hlt_fetch",  1, 1, 0, 6'h0E, S_FR,   4'h0, T_B, 16'd8);
    step("hlt_dec",    1, 1, 0, 6'h0E, S_NONE, 4'h0, T_B, 16'd8);
    step("hlt_stay",   1, 0, 0, 6'h0E, S_NONE, 4'h0, T_H, 16'd9);
    step("hlt_exit",   0, 0, 0, 6'h0E, S_NONE, 4'h0, T_H, 16'd9);
    step("hlt_idle2",  0, 0, 0, 6'h0A, S_NONE, 4'h0, T_Z, 16'd9);
    // STORE interrupted by reset in MEM
    step("rs_idle",    1, 1, 0, 6'h0A, S_NONE, 4'h0, T_Z, 16'd9);
    step("rs_fetch",   1, 1, 0, 6'h0A, S_FR,   4'h0, T_B, 16'd9);
    step("rs_dec",     1, 1, 0, 6'h0A, S_NONE, 4'h0, T_B, 16'd9);
    step("rs_exec",    1, 0, 0, 6'h0A, S_LS,   4'h0, T_B, 16'd9);
    step("rs_mem",     1, 0, 0, 6'h0A, S_MS,   4'h0, T_B, 16'd9);
    do_reset("rst_in_mem");
    // Illegal 0xF is sticky
    step("il_idle",    1, 1, 0, 6'h0F, S_NONE, 4'h0, T_Z, 16'd0);
    step("il_fetch",   1, 1, 0, 6'h0F, S_FR,   4'h0, T_B, 16'd0);
    step("il_dec",     1, 1, 0, 6'h0F, S_NONE, 4'h0, T_B, 16'd0);
    step("il_err0",    1, 1, 0, 6'h0F, S_NONE, 4'h0, T_F, 16'd0);
    step("il_err1",    0, 1, 0, 6'h0F, S_NONE, 4'h0, T_F, 16'd0);
    do_reset("rst_after_illegal");
    // Upper opcode bit set (low nibble would be ADDI) is illegal
    step("ih_idle",    1, 1, 0, 6'h18, S_NONE, 4'h0, T_Z, 16'd0);
    step("ih_fetch",   1, 1, 0, 6'h18, S_FR,   4'h0, T_B, 16'd0);
    step("ih_dec",     1, 1, 0, 6'h18, S_NONE, 4'h0, T_B, 16'd0);
    step("ih_err",     1, 1, 0, 6'h18, S_NONE, 4'h0, T_F, 16'd0);
    do_reset("rst_after_hi");
    // mem_ready on the timeout cycle wins
    step("to_idle",    1, 0, 0, 6'h0D, S_NONE, 4'h0, T_Z, 16'd0);
    for (int i = 0; i < 14; i++)
      step("tw_fwait", 1, 0, 0, 6'h0D, S_FW, 4'h0, T_B, 16'd0);
    step("tw_fready",  1, 1, 0, 6'h0D, S_FR,   4'h0, T_B, 16'd0);
    step("tw_dec",     1, 1, 0, 6'h0D, S_NONE, 4'h0, T_B, 16'd0);
    step("tw_exec",    1, 0, 0, 6'h0D, S_NONE, 4'h0, T_B, 16'd0);
    // 15 fetch cycles without mem_ready -> ERR, sticky
    for (int i = 0; i < 14; i++)
      step("to_fwait", 1, 0, 0, 6'h0D, S_FW, 4'h0, T_B, 16'd1);
    step("to_flast",   1, 0, 0, 6'h0D, S_FW,   4'h0, T_B, 16'd1);
    step("to_err0",    1, 1, 0, 6'h0D, S_NONE, 4'h0, T_F, 16'd1);
    step("to_err1",    0, 0, 0, 6'h0D, S_NONE, 4'h0, T_F, 16'd1);
    step("to_err2",    1, 1, 0, 6'h0D, S_NONE, 4'h0, T_F, 16'd1);
    do_reset("rst_after_timeout");
    step("final_idle", 0, 0, 0, 6'h00, S_NONE, 4'h0, T_Z, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OP_W, default 4, opcode input width, >= 4.
REQ-002 Parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready in FETCH/MEM.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  run enable; sampled in IDLE and at instruction boundaries.
REQ-007 op  input  OP_W  opcode from IR, valid the cycle after ir_load.
REQ-008 zero_flag  input  1  ALU zero flag, for BEQ.
REQ-009 mem_ready  input  1  memory access complete this cycle.
REQ-010 ir_load, pc_inc, pc_sel, mar_sel, mem_en, mem_sel, w_en, immed_sel, flag_en  output  1 each  datapath strobes (mem_sel 1 = write, mar_sel 1 = ALU address, 0 = PC).
REQ-011 alu_func  output  4  ALU operation.
REQ-012 busy, halted, fault  output  1 each  status.
REQ-013 instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-014 Moore FSM, states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; strobes decoded from state and latched opcode op_q only.
REQ-015 Opcode map (op[3:0], op[OP_W-1:4] = 0): 0x0-0x7 ALU reg, 0x8 ADDI, 0x9 LOAD, 0xA STORE, 0xB JMP, 0xC BEQ, 0xD NOP, 0xE HALT; 0xF or any nonzero upper bit = illegal.
REQ-016 IDLE: all strobes 0, busy 0; en=1 -> FETCH.
REQ-017 FETCH: mem_en=1, mem_sel=0, mar_sel=0; on mem_ready, ir_load=1 and pc_inc=1 that same cycle, -> DECODE.
REQ-018 DECODE: op latched into op_q; illegal -> ERR, HALT -> HALT, else -> EXEC.
REQ-019 EXEC ALU reg: alu_func=op_q[3:0], flag_en=1, -> WB.
REQ-020 EXEC ADDI: immed_sel=1, alu_func=0x0, flag_en=1, -> WB.
REQ-021 EXEC LOAD/STORE: immed_sel=1, alu_func=0x0, flag_en=0, -> MEM.
REQ-022 MEM: mem_en=1, mar_sel=1, mem_sel=1 for STORE / 0 for LOAD; on mem_ready LOAD -> WB, STORE -> boundary.
REQ-023 EXEC JMP: pc_sel=1 -> boundary; BEQ: pc_sel=zero_flag -> boundary; NOP: no strobes -> boundary.
REQ-024 WB: w_en=1 for exactly one cycle -> boundary.
REQ-025 Boundary: instr_cnt += 1 (wraps at 2^CNT_W); next state FETCH if en=1, else IDLE.
REQ-026 en deasserted mid-instruction does not abort; instruction completes, then IDLE.
REQ-027 HALT: halted=1, busy=0, instr_cnt += 1 on entry; exit to IDLE only when en=0.
REQ-028 Wait counter cleared on entry to FETCH/MEM, increments each cycle without mem_ready; reaching MEM_TIMEOUT without mem_ready -> ERR; mem_ready on the timeout cycle wins.
REQ-029 ERR: fault=1, all strobes 0, sticky until reset; instr_cnt not incremented.
REQ-030 busy=1 in FETCH, DECODE, EXEC, MEM, WB.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, op_q=0, wait counter 0, instr_cnt 0, all outputs 0, including mid-access.
REQ-032 First FETCH no earlier than the first rising edge after rst_n release with en=1.

Structure
REQ-033 Package ctrl_pkg holds state enum, opcode constants, ALU_ADD=4'h0.
REQ-034 Combinational sub-module ctrl_decode maps (state, op_q, zero_flag) to strobes; FSM, counters, and op_q in multicycle_ctrl.

Verification
REQ-035 ADDI (0x8), mem_ready immediate -> FETCH, DECODE, EXEC, WB: 4 cycles, immed_sel=1 and alu_func=0 in EXEC, w_en one cycle, instr_cnt=1.
REQ-036 LOAD (0x9), mem_ready delayed 3 cycles in MEM -> mem_en=1, mar_sel=1 held 4 cycles, then WB w_en=1.
REQ-037 BEQ (0xC) with zero_flag=1 then 0 -> pc_sel=1 in first EXEC, 0 in second.
REQ-038 mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> ERR after 15 cycles, fault=1 until rst_n pulse.
REQ-039 op=0xF -> ERR from DECODE; op=0xE -> halted=1, IDLE after en=0.
REQ-040 rst_n low during MEM of STORE -> all outputs 0 immediately, instr_cnt=0.
